ir_decode_unit: RTL and testbench
=================================

IR_DECODE_UNIT -- requirements
Module: ir_decode_unit

Interface
REQ-001 Parameter IW, default 16, SHALL set the instruction word width; only 16 is supported.
REQ-002 Parameter FW, default 4, SHALL set the flags width; only 4 is supported.
REQ-003 The module SHALL have the following ports; reset is reset, asynchronous, active-high; clock is clock:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous active-high reset
- ir_load  input  1  capture instr_in into the instruction register (IR) this edge
- instr_in  input  16  instruction word from instruction memory
- flags_load  input  1  capture alu_flags_in into the flags register this edge
- alu_flags_in  input  4  ALU flags {carry, overflow, negative, zero} in bits [3:0]
- ir_out  output  16  current IR contents
- opcode_out  output  27  {RX[26:25], RY[24:23], one-hot class[22:0]} decoded from IR
- imm_out  output  8  IR[7:0]
- flags_reg  output  4  registered flags, with zero in bit 0 and negative in bit 1
- instr_count  output  16  number of IR loads since reset

Function
REQ-004 IR SHALL load instr_in on the rising clock edge when ir_load=1, and SHALL hold its value otherwise.
REQ-005 Instruction fields SHALL be: opcode IR[15:12], RX IR[11:10], RY IR[9:8], imm IR[7:0].
REQ-006 opcode_out[26:25] SHALL equal RX, and opcode_out[24:23] SHALL equal RY.
REQ-007 opcode_out[22:0] SHALL be decoded combinationally from the IR, with no extra cycle of latency; new values are valid in the cycle after an ir_load edge.
REQ-008 The one-hot mapping (opcode -> bit) SHALL be:
- 0000 -> 0 (NOOP)
- 0001 -> 1+RY (input/GCD group, bits 1-4)
- 0010 -> 5 (MOVE)
- 0011 -> 6 (LOADI/LOADP)
- 0100 -> 7 (ADD); 0101 -> 8 (ADDI); 0110 -> 9 (SUB); 0111 -> 10 (SUBI)
- 1000 -> 11 (LOAD); 1001 -> 12 (LOADF); 1010 -> 13 (STORE); 1011 -> 14 (STOREF)
- 1100 -> 15 (SHIFTL) if IR[8]=0, 16 (SHIFTR) if IR[8]=1
- 1101 -> 17 (CMP); 1110 -> 18 (JUMP)
- 1111 -> 19+RY: BRE/BRZ=19, BRNE/BRNZ=20, BRG=21, BRGE=22
REQ-009 Exactly one bit of opcode_out[22:0] SHALL be set for every IR value, because all 16 opcodes are legal and there is no illegal-instruction state.
REQ-010 flags_reg SHALL load alu_flags_in on the rising edge when flags_load=1, and SHALL hold its value otherwise; the update is visible in the following cycle.
REQ-011 ir_load and flags_load SHALL act independently; asserting both in the same cycle SHALL update both registers on the same edge.
REQ-012 instr_count SHALL increment by 1 on every edge with ir_load=1, including reloads of an identical word, and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-013 imm_out and ir_out SHALL be direct views of the IR, with no added latency.

Reset
REQ-014 Asserting reset SHALL immediately clear IR, flags_reg and instr_count to 0, independent of clock.
REQ-015 During reset, opcode_out SHALL be 27'h0000001 (NOOP, RX=RY=0) and imm_out SHALL be 0.
REQ-016 Reset asserted while ir_load or flags_load is high SHALL take priority; no capture SHALL occur while reset is high.
REQ-017 After reset deassertion, the first rising edge with ir_load=1 SHALL capture normally.

Structure
REQ-018 A shared package SHALL hold the opcode-field constants (16 four-bit codes), the one-hot bit index constants 0-22, the field bit positions, and the flag bit indices ZERO=0, NEG=1, OVF=2, CARRY=3.
REQ-019 The one-hot decoder SHALL be a purely combinational sub-module named opcode_decoder (16-bit IR in, 27-bit opcode_out out).
REQ-020 The registers (IR, flags, counter) SHALL reside in ir_decode_unit.

Verification
REQ-021 The bench SHALL cover reset: assert reset mid-cycle with ir_load=1 -> ir_out=0, opcode_out=27'h0000001, flags_reg=0 and instr_count=0 immediately.
REQ-022 The bench SHALL cover ADD decode: instr_in=16'h4600 with ir_load pulse -> next cycle opcode_out=27'h3000080 and imm_out=8'h00.
REQ-023 The bench SHALL cover BRG decode: instr_in=16'hF205 -> opcode_out=27'h1200000 and imm_out=8'h05; then ir_load=0 with instr_in=16'h0000 -> outputs unchanged.
REQ-024 The bench SHALL cover SHIFTR decode: instr_in=16'hCD00 -> opcode_out=27'h6810000.
REQ-025 The bench SHALL cover flags: flags_load=1, alu_flags_in=4'b0011, with ir_load=1 on the same edge -> both update, flags_reg=4'b0011; then flags_load=0 with inputs changing -> flags_reg holds.
REQ-026 The bench SHALL cover counter wrap and decode exhaustion: 65536 ir_load pulses -> instr_count returns to 0; a sweep of all 65536 IR values -> opcode_out[22:0] is one-hot every time and matches the REQ-008 table.

Source files
------------

// File: rtl/ir_decode_unit_pkg.sv
// ir_decode_unit_pkg: opcode codes, one-hot class indices, IR field positions and flag indices
package ir_decode_unit_pkg;
    typedef enum logic [3:0] {
        OP_NOOP   = 4'h0,
        OP_IN     = 4'h1,
        OP_MOVE   = 4'h2,
        OP_LOADI  = 4'h3,
        OP_ADD    = 4'h4,
        OP_ADDI   = 4'h5,
        OP_SUB    = 4'h6,
        OP_SUBI   = 4'h7,
        OP_LOAD   = 4'h8,
        OP_LOADF  = 4'h9,
        OP_STORE  = 4'hA,
        OP_STOREF = 4'hB,
        OP_SHIFT  = 4'hC,
        OP_CMP    = 4'hD,
        OP_JUMP   = 4'hE,
        OP_BR     = 4'hF
    } opcode_e;
    localparam int B_NOOP   = 0;
    localparam int B_IN     = 1;
    localparam int B_MOVE   = 5;
    localparam int B_LOADI  = 6;
    localparam int B_ADD    = 7;
    localparam int B_ADDI   = 8;
    localparam int B_SUB    = 9;
    localparam int B_SUBI   = 10;
    localparam int B_LOAD   = 11;
    localparam int B_LOADF  = 12;
    localparam int B_STORE  = 13;
    localparam int B_STOREF = 14;
    localparam int B_SHIFTL = 15;
    localparam int B_SHIFTR = 16;
    localparam int B_CMP    = 17;
    localparam int B_JUMP   = 18;
    localparam int B_BRE    = 19;
    localparam int B_BRNE   = 20;
    localparam int B_BRG    = 21;
    localparam int B_BRGE   = 22;
    localparam int NCLS     = 23;
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RX_HI  = 11;
    localparam int RX_LO  = 10;
    localparam int RY_HI  = 9;
    localparam int RY_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int F_ZERO  = 0;
    localparam int F_NEG   = 1;
    localparam int F_OVF   = 2;
    localparam int F_CARRY = 3;
endpackage

// File: rtl/ir_decode_unit_decoder.sv
// opcode_decoder: combinational IR -> {RX, RY, one-hot instruction class}
module opcode_decoder
    import ir_decode_unit_pkg::*;
(
    input  logic [15:0] ir,
    output logic [26:0] opcode_out
);
    logic [4:0] idx;
    logic [1:0] ry;
    always_comb begin
        ry  = ir[RY_HI:RY_LO];
        idx = 5'(B_NOOP);
        case (opcode_e'(ir[OP_HI:OP_LO]))
            OP_NOOP:   idx = 5'(B_NOOP);
            OP_IN:     idx = 5'(B_IN) + {3'b0, ry};
            OP_MOVE:   idx = 5'(B_MOVE);
            OP_LOADI:  idx = 5'(B_LOADI);
            OP_ADD:    idx = 5'(B_ADD);
            OP_ADDI:   idx = 5'(B_ADDI);
            OP_SUB:    idx = 5'(B_SUB);
            OP_SUBI:   idx = 5'(B_SUBI);
            OP_LOAD:   idx = 5'(B_LOAD);
            OP_LOADF:  idx = 5'(B_LOADF);
            OP_STORE:  idx = 5'(B_STORE);
            OP_STOREF: idx = 5'(B_STOREF);
            OP_SHIFT:  idx = ir[RY_LO] ? 5'(B_SHIFTR) : 5'(B_SHIFTL);
            OP_CMP:    idx = 5'(B_CMP);
            OP_JUMP:   idx = 5'(B_JUMP);
            OP_BR:     idx = 5'(B_BRE) + {3'b0, ry};
        endcase
        opcode_out = {ir[RX_HI:RX_LO], ry, NCLS'(1) << idx};
    end
endmodule

// File: rtl/ir_decode_unit.sv
// ir_decode_unit: instruction register, flags register, load counter and one-hot decode
module ir_decode_unit
    import ir_decode_unit_pkg::*;
#(
    parameter int IW = 16,
    parameter int FW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ir_load,
    input  logic [IW-1:0] instr_in,
    input  logic          flags_load,
    input  logic [FW-1:0] alu_flags_in,
    output logic [IW-1:0] ir_out,
    output logic [26:0]   opcode_out,
    output logic [7:0]    imm_out,
    output logic [FW-1:0] flags_reg,
    output logic [15:0]   instr_count
);
    logic [IW-1:0] ir_q, ir_d;
    logic [FW-1:0] flags_q, flags_d;
    logic [15:0]   cnt_q, cnt_d;
    always_comb begin
        ir_d    = ir_load ? instr_in : ir_q;
        flags_d = flags_load ? alu_flags_in : flags_q;
        cnt_d   = ir_load ? cnt_q + 16'd1 : cnt_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ir_q    <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            ir_q    <= ir_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end
    opcode_decoder u_dec (
        .ir         (ir_q),
        .opcode_out (opcode_out)
    );
    assign ir_out      = ir_q;
    assign imm_out     = ir_q[IMM_HI:0];
    assign flags_reg   = flags_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_ir_decode_unit.sv
// tb_ir_decode_unit: random and directed stimulus checked against a behavioural model
module tb_ir_decode_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ir_load = 1'b0;
    logic [15:0] instr_in = '0;
    logic        flags_load = 1'b0;
    logic [3:0]  alu_flags_in = '0;
    logic [15:0] ir_out;
    logic [26:0] opcode_out;
    logic [7:0]  imm_out;
    logic [3:0]  flags_reg;
    logic [15:0] instr_count;
    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    logic [15:0] m_ir;
    logic [3:0]  m_flags;
    logic [15:0] m_cnt;

    ir_decode_unit dut (
        .clock        (clock),
        .reset        (reset),
        .ir_load      (ir_load),
        .instr_in     (instr_in),
        .flags_load   (flags_load),
        .alu_flags_in (alu_flags_in),
        .ir_out       (ir_out),
        .opcode_out   (opcode_out),
        .imm_out      (imm_out),
        .flags_reg    (flags_reg),
        .instr_count  (instr_count)
    );

    always #5 clock = ~clock;

    function automatic logic [26:0] exp_op(logic [15:0] w);
        int o  = int'(w[15:12]);
        int ry = int'(w[9:8]);
        int idx;
        if (o == 0)       idx = 0;
        else if (o == 1)  idx = 1 + ry;
        else if (o <= 11) idx = o + 3;
        else if (o == 12) idx = 15 + int'(w[8]);
        else if (o <= 14) idx = o + 4;
        else              idx = 19 + ry;
        return {w[11:10], w[9:8], 23'(1) << idx};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ir    <= '0;
            m_flags <= '0;
            m_cnt   <= '0;
        end else begin
            if (ir_load) begin
                m_ir  <= instr_in;
                m_cnt <= m_cnt + 16'd1;
            end
            if (flags_load) m_flags <= alu_flags_in;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("ir_out", 32'(ir_out), 32'(m_ir));
            chk("opcode_out", 32'(opcode_out), 32'(exp_op(m_ir)));
            chk("imm_out", 32'(imm_out), 32'(m_ir[7:0]));
            chk("flags_reg", 32'(flags_reg), 32'(m_flags));
            chk("instr_count", 32'(instr_count), 32'(m_cnt));
            chk("onehot", 32'($countones(opcode_out[22:0])), 32'd1);
        end
    end

    task automatic step(logic ld, logic [15:0] ins, logic fl, logic [3:0] af);
        @(negedge clock);
        ir_load = ld;
        instr_in = ins;
        flags_load = fl;
        alu_flags_in = af;
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_opcode", 32'(opcode_out), 32'h0000001);
        chk("rst_imm", 32'(imm_out), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cmp_en = 1'b1;
        step(1'b1, 16'h4600, 1'b0, 4'h0);
        chk("add_opcode", 32'(opcode_out), 32'h3000080);
        chk("add_imm", 32'(imm_out), 32'h00);
        step(1'b1, 16'hF205, 1'b0, 4'h0);
        chk("brg_opcode", 32'(opcode_out), 32'h1200000);
        chk("brg_imm", 32'(imm_out), 32'h05);
        step(1'b0, 16'h0000, 1'b0, 4'h0);
        chk("brg_hold_opcode", 32'(opcode_out), 32'h1200000);
        chk("brg_hold_ir", 32'(ir_out), 32'hF205);
        step(1'b1, 16'hCD00, 1'b0, 4'h0);
        chk("shiftr_opcode", 32'(opcode_out), 32'h6810000);
        step(1'b1, 16'h1234, 1'b1, 4'b0011);
        chk("both_flags", 32'(flags_reg), 32'h3);
        chk("both_ir", 32'(ir_out), 32'h1234);
        step(1'b0, 16'hFFFF, 1'b0, 4'b1100);
        chk("flags_hold", 32'(flags_reg), 32'h3);
        chk("ir_hold", 32'(ir_out), 32'h1234);
        chk("count_after_4", 32'(instr_count), 32'd4);
        for (int i = 0; i < 2000; i++)
            step(1'($urandom), 16'($urandom), 1'($urandom), 4'($urandom));
        #1;
        ir_load = 1'b1;
        flags_load = 1'b1;
        instr_in = 16'hABCD;
        alu_flags_in = 4'hF;
        reset = 1'b1;
        #1;
        chk("midrst_ir", 32'(ir_out), 32'h0);
        chk("midrst_opcode", 32'(opcode_out), 32'h0000001);
        chk("midrst_flags", 32'(flags_reg), 32'h0);
        chk("midrst_count", 32'(instr_count), 32'h0);
        @(posedge clock);
        #1;
        chk("rst_prio_ir", 32'(ir_out), 32'h0);
        chk("rst_prio_count", 32'(instr_count), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        ir_load = 1'b0;
        flags_load = 1'b0;
        for (int i = 1; i <= 65536; i++) begin
            step(1'b1, 16'(i), 1'b0, 4'h0);
            if (i == 1) begin
                chk("first_load_ir", 32'(ir_out), 32'h0001);
                chk("first_load_count", 32'(instr_count), 32'd1);
            end
        end
        chk("wrap_count", 32'(instr_count), 32'h0);
        chk("wrap_ir", 32'(ir_out), 32'h0);
        step(1'b0, 16'h0, 1'b0, 4'h0);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
